// File: rtl/me_feeder_if.sv
// ----------------------------------------------------------------------------
// me_feeder_if
// Bundle of the motion-estimation feeder's signals: the start/busy/done
// handshake, the current-MB and search-window memory read ports, and the
// datapath-side pixel streams with their candidate tags.
//   master : the feeder (issues memory reads, drives the datapath side)
//   slave  : the surrounding system (memories, controller, SAD datapath)
// ----------------------------------------------------------------------------
interface me_feeder_if #(
    parameter int MACRO_DIM = 16
);
    logic                           start;
    logic                           busy;
    logic                           done;

    logic                           cur_rd_en;
    logic [3:0]                     cur_addr;
    logic [0:MACRO_DIM-1][7:0]      cur_rdata;

    logic                           ref_rd_en;
    logic [5:0]                     ref_row;
    logic [5:0]                     ref_col;
    logic [0:MACRO_DIM-1][7:0]      ref_rdata;

    logic                           sel;
    logic                           en_cpr;
    logic                           en_spr;
    logic                           valid;
    logic [0:MACRO_DIM-1][7:0]      pixel_cpr_out;
    logic [0:MACRO_DIM-1][7:0]      pixel_spr_out;
    logic [5:0]                     cand_x;
    logic [5:0]                     cand_y;

    modport master (
        input  start, cur_rdata, ref_rdata,
        output busy, done,
        output cur_rd_en, cur_addr,
        output ref_rd_en, ref_row, ref_col,
        output sel, en_cpr, en_spr, valid,
        output pixel_cpr_out, pixel_spr_out, cand_x, cand_y
    );

    modport slave (
        output start, cur_rdata, ref_rdata,
        input  busy, done,
        input  cur_rd_en, cur_addr,
        input  ref_rd_en, ref_row, ref_col,
        input  sel, en_cpr, en_spr, valid,
        input  pixel_cpr_out, pixel_spr_out, cand_x, cand_y
    );
endinterface

// File: rtl/me_feeder.sv
// ----------------------------------------------------------------------------
// me_feeder
// Sequences one full-search motion estimation pass: loads the current
// macroblock row by row, then streams every search-window row segment
// (column-major) to the SAD datapath and tags completed candidates.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : me_feeder_if.master (handshake, memory reads, datapath side)
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start; all outputs quiet
// LOAD_CUR | reading current-MB rows 0..MACRO_DIM-1
// STREAM   | reading search-window segments, col outer / row inner
// DRAIN    | letting the last candidate leave the valid delay line
// ----------------------------------------------------------------------------
module me_feeder #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int PIPE_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    me_feeder_if.master bus
);
    localparam int ROW_MAX = SEARCH_DIM - 1;
    localparam int COL_MAX = SEARCH_DIM - MACRO_DIM;
    localparam int DRN_W   = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD_CUR, STREAM, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cur_addr_q;
    logic [5:0]         ref_row_q, ref_col_q;
    logic [DRN_W-1:0]   drain_q;
    logic               done_q;
    logic               en_cpr_q, en_spr_q;
    logic [5:0]         spr_row_q, spr_col_q;
    logic               vld_q [PIPE_LAT];
    logic [5:0]         cx_q  [PIPE_LAT];
    logic [5:0]         cy_q  [PIPE_LAT];

    logic busy, cur_rd_en, ref_rd_en;
    logic last_cur, last_ref, cand_now;

    assign last_cur = (cur_addr_q == 4'(MACRO_DIM - 1));
    assign last_ref = (ref_row_q == 6'(ROW_MAX)) && (ref_col_q == 6'(COL_MAX));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start)      state_d = LOAD_CUR;
            LOAD_CUR: if (last_cur)       state_d = STREAM;
            STREAM:   if (last_ref)       state_d = DRAIN;
            DRAIN:    if (drain_q == '0)  state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy      = (state_q != IDLE);
        cur_rd_en = (state_q == LOAD_CUR);
        ref_rd_en = (state_q == STREAM);
    end

    // Address counters return to zero on their last step so that the
    // address outputs read 0 whenever the feeder is not reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q <= '0;
            ref_row_q  <= '0;
            ref_col_q  <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            if (cur_rd_en) cur_addr_q <= last_cur ? 4'd0 : cur_addr_q + 4'd1;
            if (ref_rd_en) begin
                if (ref_row_q == 6'(ROW_MAX)) begin
                    ref_row_q <= '0;
                    ref_col_q <= (ref_col_q == 6'(COL_MAX)) ? 6'd0 : ref_col_q + 6'd1;
                end else begin
                    ref_row_q <= ref_row_q + 6'd1;
                end
            end
            // DRAIN timer: loaded with PIPE_LAT, leaves at terminal count 0
            if (ref_rd_en && last_ref)
                drain_q <= DRN_W'(PIPE_LAT);
            else if (state_q == DRAIN && drain_q != '0)
                drain_q <= drain_q - DRN_W'(1);
            done_q <= (state_q == DRAIN) && (drain_q == '0);
        end
    end

    // Read-data alignment: memory data lands one cycle after the read enable,
    // so the enables and the segment coordinates are delayed by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_cpr_q  <= 1'b0;
            en_spr_q  <= 1'b0;
            spr_row_q <= '0;
            spr_col_q <= '0;
        end else begin
            en_cpr_q  <= cur_rd_en;
            en_spr_q  <= ref_rd_en;
            spr_row_q <= ref_rd_en ? ref_row_q : 6'd0;
            spr_col_q <= ref_rd_en ? ref_col_q : 6'd0;
        end
    end

    // A candidate's last row arrives when the segment row reaches MACRO_DIM-1.
    assign cand_now = en_spr_q && (spr_row_q >= 6'(MACRO_DIM - 1));

    // Valid/candidate delay line matching the SAD pipeline latency; payload
    // is zeroed on empty slots so cand_x/cand_y stay 0 between candidates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                vld_q[i] <= 1'b0;
                cx_q[i]  <= '0;
                cy_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= cand_now;
            cx_q[0]  <= cand_now ? spr_col_q : 6'd0;
            cy_q[0]  <= cand_now ? spr_row_q - 6'(MACRO_DIM - 1) : 6'd0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                cx_q[i]  <= cx_q[i-1];
                cy_q[i]  <= cy_q[i-1];
            end
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done_q;
    assign bus.cur_rd_en     = cur_rd_en;
    assign bus.cur_addr      = cur_addr_q;
    assign bus.ref_rd_en     = ref_rd_en;
    assign bus.ref_row       = ref_row_q;
    assign bus.ref_col       = ref_col_q;
    assign bus.en_cpr        = en_cpr_q;
    assign bus.en_spr        = en_spr_q;
    assign bus.sel           = en_cpr_q;
    assign bus.pixel_cpr_out = en_cpr_q ? bus.cur_rdata : '0;
    assign bus.pixel_spr_out = en_spr_q ? bus.ref_rdata : '0;
    assign bus.valid         = vld_q[PIPE_LAT-1];
    assign bus.cand_x        = cx_q[PIPE_LAT-1];
    assign bus.cand_y        = cy_q[PIPE_LAT-1];

endmodule

// File: tb/tb_me_feeder.sv
// ----------------------------------------------------------------------------
// tb_me_feeder
// Self-checking bench for me_feeder. A timeline model computes, for every
// cycle, what each output must be from the cycle's offset since start was
// accepted. A reactive memory model returns row-coded data for real reads and
// random data otherwise.
// ----------------------------------------------------------------------------
module tb_me_feeder;
    localparam int MD     = 16;
    localparam int SD     = 48;
    localparam int PL     = 2;
    localparam int NCOL   = SD - MD + 1;          // 33 column positions
    localparam int NPOS   = NCOL * SD;            // 1584 segment reads
    localparam int T_DONE = MD + NPOS + 2 + PL;   // 1604
    localparam int W      = MD * 8;

    typedef logic [0:MD-1][7:0] row_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    me_feeder_if #(.MACRO_DIM(MD)) bus();

    me_feeder #(.MACRO_DIM(MD), .SEARCH_DIM(SD), .PIPE_LAT(PL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int edge_n     = -1;
    int n_checks   = 0;
    int n_fail     = 0;
    int vld_total  = 0;
    int done_total = 0;
    int runs[$];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, edge_n + 1);
        end
    endtask

    function automatic row_t code_cur(input int a);
        row_t r;
        for (int i = 0; i < MD; i++) r[i] = 8'((a << 4) | i);
        return r;
    endfunction

    function automatic row_t code_ref(input int row, input int col);
        row_t r;
        for (int i = 0; i < MD; i++) r[i] = 8'(row * 37 + (col + i) * 11 + 1);
        return r;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < MD; i++) r[i] = 8'($urandom);
        return r;
    endfunction

    // memory model: data one cycle after the read enable, garbage otherwise
    initial begin
        logic       ce, re;
        logic [3:0] ca;
        logic [5:0] rr, rc;
        bus.cur_rdata = '0;
        bus.ref_rdata = '0;
        forever begin
            @(negedge clk);
            ce = bus.cur_rd_en; ca = bus.cur_addr;
            re = bus.ref_rd_en; rr = bus.ref_row; rc = bus.ref_col;
            @(posedge clk);
            #1;
            bus.cur_rdata = ce ? code_cur(int'(ca)) : rand_row();
            bus.ref_rdata = re ? code_ref(int'(rr), int'(rc)) : rand_row();
        end
    end

    // timeline reference model, evaluated mid-cycle
    logic       e_cur_en, e_ref_en, e_cpr, e_spr, e_valid, e_busy, e_done;
    logic [3:0] e_addr;
    logic [5:0] e_row, e_col, e_cx, e_cy;
    row_t       e_pcpr, e_pspr;

    always @(negedge clk) begin
        int t, k;
        e_cur_en = 0; e_ref_en = 0; e_cpr = 0; e_spr = 0; e_valid = 0;
        e_busy = 0; e_done = 0; e_addr = 0; e_row = 0; e_col = 0;
        e_cx = 0; e_cy = 0; e_pcpr = '0; e_pspr = '0;
        foreach (runs[j]) begin
            t = edge_n + 1 - runs[j];
            if (t >= 1 && t <= MD) begin
                e_cur_en = 1; e_addr = 4'(t - 1);
            end
            if (t >= MD + 1 && t <= MD + NPOS) begin
                k = t - MD - 1;
                e_ref_en = 1; e_row = 6'(k % SD); e_col = 6'(k / SD);
            end
            if (t >= 2 && t <= MD + 1) begin
                e_cpr = 1; e_pcpr = code_cur(t - 2);
            end
            if (t >= MD + 2 && t <= MD + 1 + NPOS) begin
                k = t - MD - 2;
                e_spr = 1; e_pspr = code_ref(k % SD, k / SD);
            end
            k = t - PL - MD - 2;
            if (k >= 0 && k < NPOS && (k % SD) >= MD - 1) begin
                e_valid = 1; e_cx = 6'(k / SD); e_cy = 6'((k % SD) - (MD - 1));
            end
            if (t >= 1 && t <= T_DONE - 1) e_busy = 1;
            if (t == T_DONE) e_done = 1;
        end
        chk("cur_rd_en", W'(bus.cur_rd_en), W'(e_cur_en));
        chk("cur_addr",  W'(bus.cur_addr),  W'(e_addr));
        chk("ref_rd_en", W'(bus.ref_rd_en), W'(e_ref_en));
        chk("ref_row",   W'(bus.ref_row),   W'(e_row));
        chk("ref_col",   W'(bus.ref_col),   W'(e_col));
        chk("en_cpr",    W'(bus.en_cpr),    W'(e_cpr));
        chk("en_spr",    W'(bus.en_spr),    W'(e_spr));
        chk("sel",       W'(bus.sel),       W'(e_cpr));
        chk("valid",     W'(bus.valid),     W'(e_valid));
        chk("busy",      W'(bus.busy),      W'(e_busy));
        chk("done",      W'(bus.done),      W'(e_done));
        chk("pix_cpr",   bus.pixel_cpr_out, e_pcpr);
        chk("pix_spr",   bus.pixel_spr_out, e_pspr);
        if (e_valid) begin
            chk("cand_x", W'(bus.cand_x), W'(e_cx));
            chk("cand_y", W'(bus.cand_y), W'(e_cy));
        end
        if (bus.valid === 1'b1) vld_total++;
        if (bus.done === 1'b1)  done_total++;
    end

    task automatic check_zero();
        chk("z_busy",    W'(bus.busy),      '0);
        chk("z_done",    W'(bus.done),      '0);
        chk("z_cur_en",  W'(bus.cur_rd_en), '0);
        chk("z_cur_adr", W'(bus.cur_addr),  '0);
        chk("z_ref_en",  W'(bus.ref_rd_en), '0);
        chk("z_ref_row", W'(bus.ref_row),   '0);
        chk("z_ref_col", W'(bus.ref_col),   '0);
        chk("z_en_cpr",  W'(bus.en_cpr),    '0);
        chk("z_en_spr",  W'(bus.en_spr),    '0);
        chk("z_sel",     W'(bus.sel),       '0);
        chk("z_valid",   W'(bus.valid),     '0);
        chk("z_cand_x",  W'(bus.cand_x),    '0);
        chk("z_cand_y",  W'(bus.cand_y),    '0);
        chk("z_pix_cpr", bus.pixel_cpr_out, '0);
        chk("z_pix_spr", bus.pixel_spr_out, '0);
    endtask

    // called at posedge+1; start is sampled at the following edge
    task automatic pulse_start();
        bit acc;
        int t;
        acc = rst_n;
        foreach (runs[j]) begin
            t = edge_n + 1 - runs[j];
            if (t >= 1 && t <= T_DONE - 1) acc = 0;
        end
        bus.start = 1'b1;
        if (acc) runs.push_back(edge_n + 1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // advance to posedge+1 of the cycle with offset t from run start s
    task automatic to_period(input int s, input int t);
        while (edge_n < s + t - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int s, bv, bd;
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle($urandom_range(4, 20));
        check_zero();

        // run A with start pulses that must be ignored, then back-to-back run B
        bv = vld_total; bd = done_total;
        pulse_start();
        s = runs[runs.size() - 1];
        to_period(s, 5);    pulse_start();
        to_period(s, 800);  pulse_start();
        to_period(s, 1603); pulse_start();
        to_period(s, T_DONE);
        chk("a_valid_cnt", W'(vld_total - bv), W'(NCOL * NCOL));
        pulse_start();
        chk("a_done_cnt", W'(done_total - bd), W'(1));

        // run B: random ignored starts, then reset mid-search
        s = runs[runs.size() - 1];
        to_period(s, $urandom_range(2, 400)); pulse_start();
        to_period(s, $urandom_range(420, 880)); pulse_start();
        to_period(s, 900);
        rst_n = 1'b0;
        runs.delete();
        #1 check_zero();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle($urandom_range(3, 30));
        check_zero();

        // run C: full search after reset must be clean and complete
        bv = vld_total; bd = done_total;
        pulse_start();
        s = runs[runs.size() - 1];
        to_period(s, $urandom_range(2, 700)); pulse_start();
        to_period(s, $urandom_range(710, 1603)); pulse_start();
        to_period(s, T_DONE + 1);
        chk("c_valid_cnt", W'(vld_total - bv), W'(NCOL * NCOL));
        chk("c_done_cnt",  W'(done_total - bd), W'(1));
        idle(5);
        check_zero();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
